// File: rtl/fb_fill_master_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_fill_master_if
// Description : Bus bundle for the frame-buffer fill master. Carries the CSR
//               slave port (s1_*) and the Avalon-MM write master port (m1_*).
//               modport master : view of the fill engine itself
//               modport slave  : view of the surrounding system (CPU side
//                                drives s1_*, memory side answers m1_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_fill_master_if;
  logic [7:0]  s1_address;
  logic [31:0] s1_writedata;
  logic        s1_write;
  logic [31:0] s1_readdata;
  logic        s1_waitrequest;
  logic [31:0] m1_address;
  logic [31:0] m1_writedata;
  logic        m1_write;
  logic        m1_waitrequest;
  logic        m1_read;

  modport master (
    input  s1_address, s1_writedata, s1_write, m1_waitrequest,
    output s1_readdata, s1_waitrequest, m1_address, m1_writedata, m1_write, m1_read
  );

  modport slave (
    output s1_address, s1_writedata, s1_write, m1_waitrequest,
    input  s1_readdata, s1_waitrequest, m1_address, m1_writedata, m1_write, m1_read
  );
endinterface
`default_nettype wire

// File: rtl/fb_fill_master.sv
`default_nettype none
// ============================================================================
// Module      : fb_fill_master
// Description : Fills a WIDTH x HEIGHT rectangle of 32-bit words in memory with
//               a constant colour, one Avalon-MM write per cycle when the slave
//               does not stall. Rows are STRIDE bytes apart starting at BASE.
// Ports       : clock  - sole clock, rising edge
//               reset  - asynchronous, active-high
//               bus    - s1_* CSR slave (word index 0x00..0x05) and
//                        m1_* write-only Avalon-MM master
//               irq    - done & irq_en
// Revision    : 1.0 - initial release
// ============================================================================
module fb_fill_master #(
  parameter logic [31:0] DEFAULT_BUFFER = 32'h0800_0000,
  parameter logic [31:0] DEFAULT_STRIDE = 32'd1024
) (
  input  wire logic           clock,
  input  wire logic           reset,
  fb_fill_master_if.master    bus,
  output logic                irq
);

  localparam logic [7:0] CSR_BASE   = 8'h00;
  localparam logic [7:0] CSR_STRIDE = 8'h01;
  localparam logic [7:0] CSR_WIDTH  = 8'h02;
  localparam logic [7:0] CSR_HEIGHT = 8'h03;
  localparam logic [7:0] CSR_COLOR  = 8'h04;
  localparam logic [7:0] CSR_CTRL   = 8'h05;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] base;
  logic [31:0] stride;
  logic [15:0] width;
  logic [15:0] height;
  logic [31:0] color;
  logic        irq_en;
  logic        done;
  logic [15:0] col;
  logic [15:0] row;
  logic [31:0] row_addr;
  logic [31:0] wr_addr;
  logic        wr_req;

  logic        busy;
  logic        ctrl_wr;
  logic        start_idle;
  logic        dims_ok;
  logic        accept;
  logic        last_col;
  logic        last_row;
  logic        finish;
  logic [31:0] next_row_addr;

  assign busy          = (state == RUN);
  assign ctrl_wr       = bus.s1_write && (bus.s1_address == CSR_CTRL);
  // Start is only honoured from IDLE; in RUN the bit is simply dropped.
  assign start_idle    = ctrl_wr && bus.s1_writedata[0] && !busy;
  assign dims_ok       = (width != 16'd0) && (height != 16'd0);
  assign accept        = wr_req && !bus.m1_waitrequest;
  assign last_col      = (col == width - 16'd1);
  assign last_row      = (row == height - 16'd1);
  assign finish        = busy && accept && last_col && last_row;
  assign next_row_addr = row_addr + stride;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      base     <= DEFAULT_BUFFER;
      stride   <= DEFAULT_STRIDE;
      width    <= 16'd0;
      height   <= 16'd0;
      color    <= 32'd0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      col      <= 16'd0;
      row      <= 16'd0;
      row_addr <= 32'd0;
      wr_addr  <= 32'd0;
      wr_req   <= 1'b0;
    end else begin
      // Geometry/colour registers are frozen during a fill so the engine
      // never sees a half-updated rectangle.
      if (bus.s1_write && !busy) begin
        case (bus.s1_address)
          CSR_BASE:   base   <= bus.s1_writedata;
          CSR_STRIDE: stride <= bus.s1_writedata;
          CSR_WIDTH:  width  <= bus.s1_writedata[15:0];
          CSR_HEIGHT: height <= bus.s1_writedata[15:0];
          CSR_COLOR:  color  <= bus.s1_writedata;
          default:    ;
        endcase
      end
      if (ctrl_wr) begin
        irq_en <= bus.s1_writedata[1];
      end

      // Setting done wins over a clear landing on the same edge, so a
      // completion is never lost.
      if (finish || (start_idle && !dims_ok)) begin
        done <= 1'b1;
      end else if ((ctrl_wr && bus.s1_writedata[2]) || start_idle) begin
        done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_idle && dims_ok) begin
            state    <= RUN;
            col      <= 16'd0;
            row      <= 16'd0;
            row_addr <= base;
            wr_addr  <= base;
            wr_req   <= 1'b1;
          end
        end
        RUN: begin
          // wr_addr tracks row_addr + 4*col incrementally; address, data and
          // request only move on an accepted beat, so a stall holds them.
          if (accept) begin
            if (!last_col) begin
              col     <= col + 16'd1;
              wr_addr <= wr_addr + 32'd4;
            end else if (!last_row) begin
              col      <= 16'd0;
              row      <= row + 16'd1;
              row_addr <= next_row_addr;
              wr_addr  <= next_row_addr;
            end else begin
              state  <= IDLE;
              wr_req <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          wr_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.s1_readdata = 32'd0;
    case (bus.s1_address)
      CSR_BASE:   bus.s1_readdata = base;
      CSR_STRIDE: bus.s1_readdata = stride;
      CSR_WIDTH:  bus.s1_readdata = {16'd0, width};
      CSR_HEIGHT: bus.s1_readdata = {16'd0, height};
      CSR_COLOR:  bus.s1_readdata = color;
      CSR_CTRL:   bus.s1_readdata = {29'd0, done, irq_en, busy};
      default:    bus.s1_readdata = 32'd0;
    endcase
  end

  assign bus.s1_waitrequest = 1'b0;
  assign bus.m1_read        = 1'b0;
  assign bus.m1_address     = wr_addr;
  assign bus.m1_writedata   = color;
  assign bus.m1_write       = wr_req;
  assign irq                = done & irq_en;

endmodule
`default_nettype wire
